// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: datapath width, canonical NOP and
// the IF/DE pipeline register layout.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            valid;
  } if_de_t;

  // Bubble written into IF/DE on reset and on any redirect flush.
  localparam if_de_t IF_DE_BUBBLE = '{pc: '0, inst: NOP_INST, valid: 1'b0};

  // Clears the two low address bits so redirect targets are word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage (master) and the
// instruction memory (slave); read data is combinational on the address.
interface fetch_stage_if;
  import core_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_stage_if_de_reg.sv
// IF/DE pipeline register: flush inserts a NOP bubble, load captures a new
// entry, otherwise the contents hold.
module if_de_reg
  import core_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_de_t d,
  output if_de_t q
);

  if_de_t entry_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      entry_reg <= IF_DE_BUBBLE;
    end else if (load) begin
      entry_reg <= d;
    end
  end

  assign q = entry_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and fills the IF/DE register, applying trap/branch redirects and stalls.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [XLEN-1:0]   br_target_i,
  input  logic              trap_i,
  input  logic [XLEN-1:0]   trap_vector_i,
  fetch_stage_if.master     imem,
  output logic [XLEN-1:0]   pc_de_o,
  output logic [31:0]       inst_de_o,
  output logic              valid_de_o,
  output logic              misalign_o,
  output logic [XLEN-1:0]   misalign_addr_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  logic [XLEN-1:0]  pc_reg;
  logic [XLEN-1:0]  pc_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             misalign_reg;
  logic [XLEN-1:0]  misalign_addr_reg;

  logic   flush;
  logic   load;
  logic   br_misaligned;
  if_de_t capture;
  if_de_t de_q;

  // A taken branch to a target with bit[1] set is reported, not followed;
  // the CSR unit answers with a trap redirect.
  assign br_misaligned = br_taken_i && br_target_i[1];
  assign flush         = trap_i || br_taken_i;
  assign load          = !flush && !stall_i;
  assign capture       = '{pc: pc_reg, inst: imem.imem_rdata, valid: 1'b1};

  always_comb begin
    pc_next = pc_reg;
    if (trap_i) begin
      pc_next = word_align(trap_vector_i);
    end else if (br_taken_i) begin
      if (!br_target_i[1]) begin
        pc_next = word_align(br_target_i);
      end
    end else if (!stall_i) begin
      pc_next = pc_reg + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg            <= RESET_PC;
      cnt_reg           <= '0;
      misalign_reg      <= 1'b0;
      misalign_addr_reg <= '0;
    end else begin
      pc_reg       <= pc_next;
      misalign_reg <= !trap_i && br_misaligned;
      if (!trap_i && br_misaligned) begin
        misalign_addr_reg <= br_target_i;
      end
      if (load) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  if_de_reg u_if_de_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .flush (flush),
    .d     (capture),
    .q     (de_q)
  );

  assign imem.imem_addr  = pc_reg;
  assign pc_de_o         = de_q.pc;
  assign inst_de_o       = de_q.inst;
  assign valid_de_o      = de_q.valid;
  assign misalign_o      = misalign_reg;
  assign misalign_addr_o = misalign_addr_reg;
  assign fetch_cnt_o     = cnt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run compared
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] tv = '0;

  fetch_stage_if ifc ();
  fetch_stage_if ifc2 ();

  logic [31:0] pc_de, inst_de, mis_addr, cnt;
  logic        valid_de, mis;
  logic [31:0] pc_de2, inst_de2, mis_addr2, cnt2;
  logic        valid_de2, mis2;

  logic [31:0] mem [0:255];

  assign ifc.imem_rdata  = mem[ifc.imem_addr[9:2]];
  assign ifc2.imem_rdata = ~ifc2.imem_addr;

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .br_taken_i(br), .br_target_i(tgt),
    .trap_i(trap), .trap_vector_i(tv), .imem(ifc.master),
    .pc_de_o(pc_de), .inst_de_o(inst_de), .valid_de_o(valid_de),
    .misalign_o(mis), .misalign_addr_o(mis_addr), .fetch_cnt_o(cnt)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(32)) dut2 (
    .clk(clk), .rst(rst), .stall_i(stall), .br_taken_i(br), .br_target_i(tgt),
    .trap_i(trap), .trap_vector_i(tv), .imem(ifc2.master),
    .pc_de_o(pc_de2), .inst_de_o(inst_de2), .valid_de_o(valid_de2),
    .misalign_o(mis2), .misalign_addr_o(mis_addr2), .fetch_cnt_o(cnt2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of dut (RESET_PC = 0)
  logic [31:0] m_pc, m_de_pc, m_de_inst, m_mis_addr, m_cnt;
  logic        m_de_valid, m_mis;

  task automatic model_step();
    if (rst) begin
      m_pc = 32'h0; m_de_pc = 32'h0; m_de_inst = 32'h13; m_de_valid = 1'b0;
      m_mis = 1'b0; m_mis_addr = 32'h0; m_cnt = 32'h0;
    end else if (trap) begin
      m_pc = {tv[31:2], 2'b00};
      m_de_inst = 32'h13; m_de_valid = 1'b0; m_mis = 1'b0;
    end else if (br) begin
      m_de_inst = 32'h13; m_de_valid = 1'b0;
      if (tgt[1]) begin
        m_mis = 1'b1; m_mis_addr = tgt;
      end else begin
        m_pc = {tgt[31:2], 2'b00}; m_mis = 1'b0;
      end
    end else if (stall) begin
      m_mis = 1'b0;
    end else begin
      m_de_pc = m_pc; m_de_inst = mem[m_pc[9:2]]; m_de_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1; m_mis = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; br = 1'b0; trap = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_tests++; if (ifc.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", ifc.imem_addr); end
    n_tests++; if (valid_de !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_de); end
    n_tests++; if (inst_de !== 32'h13) begin n_fail++; $display("FAIL reset_inst got=%h exp=13", inst_de); end
    n_tests++; if (cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    n_tests++; if (mis !== 1'b0 || mis_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mis got=%b/%h exp=0/0", mis, mis_addr); end
    $display("[TB] reset: addr=%h valid=%b inst=%h cnt=%0d", ifc.imem_addr, valid_de, inst_de, cnt);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (pc_de !== 32'(4 * i) || valid_de !== 1'b1) begin n_fail++; $display("FAIL seq_pc[%0d] got=%h/%b exp=%h/1", i, pc_de, valid_de, 4 * i); end
      n_tests++; if (inst_de !== mem[i]) begin n_fail++; $display("FAIL seq_inst[%0d] got=%h exp=%h", i, inst_de, mem[i]); end
      $display("[TB] seq %0d: pc_de=%h inst=%h", i, pc_de, inst_de);
    end
    n_tests++; if (cnt !== 32'd4) begin n_fail++; $display("FAIL seq_cnt got=%0d exp=4", cnt); end
    n_tests++; if (ifc.imem_addr !== 32'h10) begin n_fail++; $display("FAIL seq_addr got=%h exp=10", ifc.imem_addr); end
  endtask

  task automatic test_stall();
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (ifc.imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_addr[%0d] got=%h exp=8", i, ifc.imem_addr); end
      n_tests++; if (pc_de !== 32'h4 || inst_de !== mem[1]) begin n_fail++; $display("FAIL stall_de[%0d] got=%h/%h exp=4/%h", i, pc_de, inst_de, mem[1]); end
      n_tests++; if (cnt !== 32'd2) begin n_fail++; $display("FAIL stall_cnt[%0d] got=%0d exp=2", i, cnt); end
      $display("[TB] stall %0d: addr=%h pc_de=%h cnt=%0d", i, ifc.imem_addr, pc_de, cnt);
    end
    stall = 1'b0;
  endtask

  task automatic test_branch_stall();
    br = 1'b1; tgt = 32'h40; stall = 1'b1;
    tick();
    br = 1'b0; stall = 1'b0;
    n_tests++; if (ifc.imem_addr !== 32'h40) begin n_fail++; $display("FAIL brst_addr got=%h exp=40", ifc.imem_addr); end
    n_tests++; if (valid_de !== 1'b0 || inst_de !== 32'h13) begin n_fail++; $display("FAIL brst_flush got=%b/%h exp=0/13", valid_de, inst_de); end
    tick();
    n_tests++; if (pc_de !== 32'h40 || inst_de !== mem[16] || valid_de !== 1'b1) begin n_fail++; $display("FAIL brst_next got=%h/%h exp=40/%h", pc_de, inst_de, mem[16]); end
    $display("[TB] branch+stall: pc_de=%h inst=%h", pc_de, inst_de);
  endtask

  task automatic test_trap_misalign();
    trap = 1'b1; tv = 32'h103; br = 1'b1; tgt = 32'h40;
    tick();
    trap = 1'b0; tgt = 32'h42;
    n_tests++; if (ifc.imem_addr !== 32'h100) begin n_fail++; $display("FAIL trap_addr got=%h exp=100", ifc.imem_addr); end
    n_tests++; if (valid_de !== 1'b0) begin n_fail++; $display("FAIL trap_valid got=%b exp=0", valid_de); end
    tick();
    br = 1'b0;
    n_tests++; if (ifc.imem_addr !== 32'h100) begin n_fail++; $display("FAIL mis_hold got=%h exp=100", ifc.imem_addr); end
    n_tests++; if (mis !== 1'b1 || mis_addr !== 32'h42) begin n_fail++; $display("FAIL mis_pulse got=%b/%h exp=1/42", mis, mis_addr); end
    tick();
    n_tests++; if (mis !== 1'b0 || mis_addr !== 32'h42) begin n_fail++; $display("FAIL mis_end got=%b/%h exp=0/42", mis, mis_addr); end
    n_tests++; if (pc_de !== 32'h100 || valid_de !== 1'b1) begin n_fail++; $display("FAIL mis_after got=%h/%b exp=100/1", pc_de, valid_de); end
    $display("[TB] trap/misalign: addr=%h mis_addr=%h", ifc.imem_addr, mis_addr);
  endtask

  task automatic test_wrap_reset();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (pc_de2 !== exp_pc[i] || inst_de2 !== ~exp_pc[i] || valid_de2 !== 1'b1) begin n_fail++; $display("FAIL wrap[%0d] got=%h/%h exp=%h", i, pc_de2, inst_de2, exp_pc[i]); end
      $display("[TB] wrap %0d: pc_de=%h", i, pc_de2);
    end
    br = 1'b1; tgt = 32'h42;
    tick();
    br = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (ifc2.imem_addr !== 32'hFFFF_FFF8 || valid_de2 !== 1'b0) begin n_fail++; $display("FAIL rst_redirect got=%h/%b exp=fffffff8/0", ifc2.imem_addr, valid_de2); end
    n_tests++; if (mis !== 1'b0 || mis2 !== 1'b0 || mis_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mis got=%b/%b/%h exp=0/0/0", mis, mis2, mis_addr); end
    $display("[TB] reset during redirect: addr2=%h mis=%b", ifc2.imem_addr, mis);
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      trap  = ($urandom_range(0, 15) == 0);
      br    = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      tgt   = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom)};
      tv    = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom)};
      tick();
      n_tests++; if (ifc.imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, ifc.imem_addr, m_pc); end
      n_tests++; if (valid_de !== m_de_valid || inst_de !== m_de_inst) begin n_fail++; $display("FAIL rnd_de[%0d] got=%b/%h exp=%b/%h", i, valid_de, inst_de, m_de_valid, m_de_inst); end
      if (m_de_valid) begin
        n_tests++; if (pc_de !== m_de_pc) begin n_fail++; $display("FAIL rnd_pcde[%0d] got=%h exp=%h", i, pc_de, m_de_pc); end
      end
      n_tests++; if (cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, cnt, m_cnt); end
      n_tests++; if (mis !== m_mis || mis_addr !== m_mis_addr) begin n_fail++; $display("FAIL rnd_mis[%0d] got=%b/%h exp=%b/%h", i, mis, mis_addr, m_mis, m_mis_addr); end
      $display("[TB] rnd %0d: r=%b t=%b b=%b s=%b addr=%h pc_de=%h v=%b cnt=%0d", i, rst, trap, br, stall, ifc.imem_addr, pc_de, valid_de, cnt);
    end
    rst = 1'b0; trap = 1'b0; br = 1'b0; stall = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    @(posedge clk); #1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_trap_misalign();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
